weight_pingpong_bank: RTL

//  Double-buffered (ping-pong) weight bank: one of X*Y per-PE weight stores holding (Tn/Y)*(Tm/X)*K*K words per tile.

---
 rtl/weight_pingpong_bank_pkg.sv | 37 +++
 rtl/weight_pingpong_bank_if.sv | 27 ++
 rtl/weight_pingpong_bank_sdp_ram.sv | 24 ++
 rtl/weight_pingpong_bank.sv | 134 +++++++++++++
 4 files changed

// File: rtl/weight_pingpong_bank_pkg.sv
// Shared tile-geometry defaults, fill-state encoding and sizing helpers
// for the weight bank and its RAM.
package weight_pingpong_bank_pkg;

  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_TN = 16;
  localparam int unsigned DEF_TM = 16;
  localparam int unsigned DEF_K  = 3;
  localparam int unsigned DEF_X  = 4;
  localparam int unsigned DEF_Y  = 4;
  localparam int unsigned DEF_AW = 10;

  // Number of complete tiles held: EMPTY=0, ONE=1, BOTH=2.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    BOTH  = 2'd2
  } fill_state_e;

  // Words per tile held by one PE's weight store.
  function automatic int unsigned cap_words(input int unsigned tn, input int unsigned tm,
                                            input int unsigned k, input int unsigned x,
                                            input int unsigned y);
    return (tn / y) * (tm / x) * k * k;
  endfunction

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/weight_pingpong_bank_if.sv
// Loader write port and PE-array read port of the weight bank.
interface weight_pingpong_bank_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
) ();
  logic [DW-1:0] wr_data;
  logic          wr_ena;
  logic          wr_ready;
  logic          wr_drop;
  logic [AW-1:0] wr_fill;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_release;

  // Loader / PE-array side.
  modport master (
    output wr_data, wr_ena, rd_addr, rd_release,
    input  wr_ready, wr_drop, wr_fill, rd_data, rd_valid
  );

  // Bank side.
  modport slave (
    input  wr_data, wr_ena, rd_addr, rd_release,
    output wr_ready, wr_drop, wr_fill, rd_data, rd_valid
  );
endinterface

// File: rtl/weight_pingpong_bank_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A same-address read and write return the old contents.
module weight_pingpong_bank_sdp_ram #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 288,
  parameter int unsigned AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port plus registered read; non-blocking update gives read-old-data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/weight_pingpong_bank.sv
// Ping-pong weight store: the loader fills one half while the PE array
// reads the other; halves hand over when a tile completes and is released.
module weight_pingpong_bank
  import weight_pingpong_bank_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned Tn = DEF_TN,
  parameter int unsigned Tm = DEF_TM,
  parameter int unsigned K  = DEF_K,
  parameter int unsigned X  = DEF_X,
  parameter int unsigned Y  = DEF_Y,
  parameter int unsigned AW = DEF_AW
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  weight_pingpong_bank_if.slave bus
);

  localparam int unsigned CAP = cap_words(Tn, Tm, K, X, Y);
  localparam int unsigned PAW = AW + 1;

  if (clog2(CAP) > AW) begin : g_aw_check
    $error("weight_pingpong_bank: AW too narrow for tile capacity");
  end

  fill_state_e   state, state_nxt;
  logic [AW-1:0] wr_ptr;
  logic          wr_sel, rd_sel;
  logic          wr_ready_q, rd_valid_q, wr_drop_q;
  logic          accept, tile_done, release_ok;

  logic [PAW-1:0] wr_phys, rd_phys, rd_phys_q;
  logic [AW-1:0]  rd_off;
  logic           rd_oor, rd_oor_q, rd_oor_qq;
  logic [DW-1:0]  ram_q, rd_data_q;

  // Accept/complete/release qualifiers and next tile count.
  always_comb begin
    accept     = bus.wr_ena & wr_ready_q & ~flush;
    tile_done  = accept & (wr_ptr == AW'(CAP - 1));
    release_ok = bus.rd_release & rd_valid_q & ~flush;
    state_nxt  = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      // Completion is only possible below BOTH, release only above EMPTY.
      unique case ({tile_done, release_ok})
        2'b10:   state_nxt = (state == EMPTY) ? ONE : BOTH;
        2'b01:   state_nxt = (state == BOTH) ? ONE : EMPTY;
        default: state_nxt = state;
      endcase
    end
  end

  // Tile count and its registered status flags, updated on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      wr_ready_q <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ready_q <= (state_nxt != BOTH);
      rd_valid_q <= (state_nxt != EMPTY);
    end
  end

  // Write offset and half-select bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (accept) wr_ptr <= tile_done ? '0 : wr_ptr + 1'b1;
      if (tile_done) wr_sel <= ~wr_sel;
      if (release_ok) rd_sel <= ~rd_sel;
    end
  end

  // One-cycle pulse for a write attempted while no half is free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_drop_q <= 1'b0;
    else      wr_drop_q <= ~flush & bus.wr_ena & ~wr_ready_q;
  end

  always_comb begin
    wr_phys = (wr_sel ? PAW'(CAP) : '0) + PAW'(wr_ptr);
    rd_oor  = {1'b0, bus.rd_addr} >= PAW'(CAP);
    rd_off  = rd_oor ? '0 : bus.rd_addr;
    rd_phys = (rd_sel ? PAW'(CAP) : '0) + PAW'(rd_off);
  end

  weight_pingpong_bank_sdp_ram #(
    .DW    (DW),
    .DEPTH (2 * CAP),
    .AW    (PAW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_phys),
    .wdata (bus.wr_data),
    .raddr (rd_phys_q),
    .rdata (ram_q)
  );

  // Read pipeline: address/select sample, RAM read, output register.
  // Out-of-range addresses are clamped to 0 and zeroed at the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_phys_q <= '0;
      rd_oor_q  <= 1'b0;
      rd_oor_qq <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_phys_q <= rd_phys;
      rd_oor_q  <= rd_oor;
      rd_oor_qq <= rd_oor_q;
      rd_data_q <= rd_oor_qq ? '0 : ram_q;
    end
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_drop  = wr_drop_q;
  assign bus.wr_fill  = wr_ptr;
  assign bus.rd_data  = rd_data_q;

endmodule
